// File: rtl/des_pkg.sv
// DES S-box shared definitions.
// Holds the layer geometry constants, the FSM state type and the eight
// FIPS 46-3 substitution tables, plus the single-box lookup function used
// by every lookup lane.
package des_pkg;

  localparam int SBOX_COUNT = 8;
  localparam int SLICE_W    = 6;
  localparam int NIBBLE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One 64-bit word per table row; column 0 sits in the most significant
  // nibble so each word reads left to right like the printed table.
  localparam logic [63:0] SBOX_ROWS [SBOX_COUNT][4] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
      64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
      64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
      64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
      64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
      64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
      64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
      64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
      64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

  // Row is the outer bit pair {b5,b0}, column the inner bits b4..b1.
  // Column c lives at nibble (15-c) counted from the LSB, and 15-c == ~c.
  function automatic logic [NIBBLE_W-1:0] sbox_lookup(
    input logic [2:0]         box,
    input logic [SLICE_W-1:0] val
  );
    logic [1:0]  row;
    logic [3:0]  col;
    logic [63:0] word;
    row  = {val[5], val[0]};
    col  = val[4:1];
    word = SBOX_ROWS[box][row];
    return word[{~col, 2'b00} +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// Single DES S-box lookup unit (combinational).
// Ports:
//   box_idx : which of S1..S8 to apply (0 = S1)
//   lut_in  : 6-bit slice of the key-mixed vector
//   lut_out : 4-bit substituted nibble
module des_sbox_lut
  import des_pkg::*;
(
  input  logic [2:0]          box_idx,
  input  logic [SLICE_W-1:0]  lut_in,
  output logic [NIBBLE_W-1:0] lut_out
);

  assign lut_out = sbox_lookup(box_idx, lut_in);

endmodule

// File: rtl/des_sbox_layer_seq.sv
// Sequential DES S-box substitution layer with valid/ready handshakes.
// The eight lookups are folded onto LANES lookup units over 8/LANES cycles.
// Ports:
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_valid / o_ready  : upstream handshake carrying i_vector (48 bits)
//   o_valid / i_ready  : downstream handshake carrying o_vector (32 bits)
// Box k reads i_vector[6k+5:6k] and writes o_vector[4k+3:4k].
module des_sbox_layer_seq
  import des_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [SBOX_COUNT*SLICE_W-1:0]    i_vector,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [SBOX_COUNT*NIBBLE_W-1:0]   o_vector
);

  localparam int STEPS = SBOX_COUNT / LANES;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
    $error("des_sbox_layer_seq: LANES must be 1, 2, 4 or 8");
  end

  state_t                          state_q;
  logic [2:0]                      step_q;
  logic [SBOX_COUNT*SLICE_W-1:0]   vec_q;
  logic [SBOX_COUNT*NIBBLE_W-1:0]  out_q;
  logic [SBOX_COUNT*NIBBLE_W-1:0]  out_next;
  logic                            valid_q;
  logic                            accept;
  logic                            last_step;
  logic [SBOX_COUNT*SLICE_W-1:0]   src_vec;
  logic [2:0]                      box_idx  [LANES];
  logic [SLICE_W-1:0]              lane_in  [LANES];
  logic [NIBBLE_W-1:0]             lane_out [LANES];

  // o_ready depends only on state and i_ready, never on i_valid.
  assign o_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && i_ready);
  assign accept    = i_valid && o_ready;
  assign last_step = (step_q == 3'(STEPS - 1));

  // With all eight lanes present the whole result is formed on the accept
  // edge, so the lanes must look at the incoming vector, not the latch.
  assign src_vec = (LANES == SBOX_COUNT) ? i_vector : vec_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign box_idx[l] = 3'(32'(step_q) * LANES + l);
    assign lane_in[l] = src_vec[6'(box_idx[l]) * 6'd6 +: SLICE_W];

    des_sbox_lut u_lut (
      .box_idx (box_idx[l]),
      .lut_in  (lane_in[l]),
      .lut_out (lane_out[l])
    );
  end

  // Merge this cycle's lane nibbles into the held result.
  always_comb begin
    out_next = out_q;
    for (int l = 0; l < LANES; l++) begin
      out_next[{box_idx[l], 2'b00} +: NIBBLE_W] = lane_out[l];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      vec_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            vec_q  <= i_vector;
            step_q <= '0;
            if (LANES == SBOX_COUNT) begin
              out_q   <= out_next;
              state_q <= ST_DONE;
              valid_q <= 1'b1;
            end else begin
              state_q <= ST_BUSY;
              valid_q <= 1'b0;
            end
          end else if ((state_q == ST_DONE) && i_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          out_q <= out_next;
          if (last_step) begin
            state_q <= ST_DONE;
            valid_q <= 1'b1;
            step_q  <= '0;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid  = valid_q;
  assign o_vector = out_q;

endmodule

// File: tb/tb_des_sbox_layer_seq.sv
// Bench for des_sbox_layer_seq: one instance per legal LANES value
// (index g -> LANES = 1 << g), each with its own handshake and reset.
module tb_des_sbox_layer_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [4];
  logic        valid_in  [4];
  logic        ready_out [4];
  logic [47:0] vec_in    [4];
  logic        valid_out [4];
  logic        ready_in  [4];
  logic [31:0] vec_out   [4];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_layer_seq #(.LANES(1 << g)) u_dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n[g]),
      .i_valid  (valid_in[g]),
      .o_ready  (ready_out[g]),
      .i_vector (vec_in[g]),
      .o_valid  (valid_out[g]),
      .i_ready  (ready_in[g]),
      .o_vector (vec_out[g])
    );
  end

  // FIPS 46-3 tables as printed: [box][row][column].
  int sbox_tbl [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };

  function automatic logic [31:0] ref_layer(input logic [47:0] v);
    logic [31:0] r;
    int s;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      s = int'((v >> (6 * k)) & 48'h3F);
      r = r | (32'(sbox_tbl[k][(s / 32) * 2 + s % 2][(s / 2) % 16]) << (4 * k));
    end
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom()), 32'($urandom())};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int g = 0; g < 4; g++) begin
      rst_n[g] = 1'b0; valid_in[g] = 1'b0; ready_in[g] = 1'b0; vec_in[g] = '0;
    end
    #3;
    for (int g = 0; g < 4; g++) begin
      total++; if (valid_out[g] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", g, valid_out[g]); end
      total++; if (vec_out[g] !== 32'h0) begin bad++; $display("FAIL reset_vector[%0d]: got %h want 0", g, vec_out[g]); end
      total++; if (ready_out[g] !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d]: got %b want 1", g, ready_out[g]); end
    end
    @(negedge clk);
    for (int g = 0; g < 4; g++) rst_n[g] = 1'b1;
    tick();
  endtask

  task automatic test_latency(input int g, input logic [47:0] v, input logic [31:0] golden,
                              input int steps, input string name);
    ready_in[g] = 1'b0;
    total++; if (ready_out[g] !== 1'b1) begin bad++; $display("FAIL %s_idle_ready: got %b want 1", name, ready_out[g]); end
    valid_in[g] = 1'b1; vec_in[g] = v;
    tick();
    valid_in[g] = 1'b0; vec_in[g] = ~v;
    for (int k = 1; k <= steps; k++) begin
      tick();
      total++;
      if (valid_out[g] !== (k == steps)) begin
        bad++; $display("FAIL %s_latency edge %0d: got valid=%b want %b", name, k, valid_out[g], k == steps);
      end
    end
    total++; if (vec_out[g] !== golden) begin bad++; $display("FAIL %s_golden: got %h want %h", name, vec_out[g], golden); end
    total++; if (vec_out[g] !== ref_layer(v)) begin bad++; $display("FAIL %s_model: got %h want %h", name, vec_out[g], ref_layer(v)); end
    ready_in[g] = 1'b1;
    tick();
    ready_in[g] = 1'b0;
    total++; if (valid_out[g] !== 1'b0) begin bad++; $display("FAIL %s_consume_valid: got %b want 0", name, valid_out[g]); end
    total++; if (ready_out[g] !== 1'b1) begin bad++; $display("FAIL %s_consume_ready: got %b want 1", name, ready_out[g]); end
  endtask

  task automatic test_backpressure();
    int g, n;
    logic [47:0] v, w, x;
    g = 2;
    v = rand48(); w = rand48(); x = rand48();
    ready_in[g] = 1'b0; valid_in[g] = 1'b1; vec_in[g] = v;
    tick();
    valid_in[g] = 1'b0; vec_in[g] = rand48();
    n = 0;
    while (!valid_out[g] && n < 20) begin tick(); n++; end
    total++; if (n != 2) begin bad++; $display("FAIL bp_latency: got %0d cycles want 2", n); end
    valid_in[g] = 1'b1; vec_in[g] = w;
    for (int k = 0; k < 5; k++) begin
      total++; if (valid_out[g] !== 1'b1) begin bad++; $display("FAIL bp_hold_valid c%0d: got %b want 1", k, valid_out[g]); end
      total++; if (vec_out[g] !== ref_layer(v)) begin bad++; $display("FAIL bp_hold_vector c%0d: got %h want %h", k, vec_out[g], ref_layer(v)); end
      total++; if (ready_out[g] !== 1'b0) begin bad++; $display("FAIL bp_hold_ready c%0d: got %b want 0", k, ready_out[g]); end
      tick();
    end
    vec_in[g] = x; ready_in[g] = 1'b1;
    #1;
    total++; if (ready_out[g] !== 1'b1) begin bad++; $display("FAIL bp_done_ready: got %b want 1", ready_out[g]); end
    tick();
    valid_in[g] = 1'b0; ready_in[g] = 1'b0; vec_in[g] = rand48();
    total++; if (valid_out[g] !== 1'b0) begin bad++; $display("FAIL bp_reaccept_valid: got %b want 0", valid_out[g]); end
    n = 0;
    while (!valid_out[g] && n < 20) begin tick(); n++; end
    total++; if (n != 2) begin bad++; $display("FAIL bp_reaccept_latency: got %0d cycles want 2", n); end
    total++; if (vec_out[g] !== ref_layer(x)) begin bad++; $display("FAIL bp_reaccept_vector: got %h want %h", vec_out[g], ref_layer(x)); end
    ready_in[g] = 1'b1;
    tick();
    ready_in[g] = 1'b0;
    total++; if (valid_out[g] !== 1'b0) begin bad++; $display("FAIL bp_final_valid: got %b want 0", valid_out[g]); end
  endtask

  task automatic test_back_to_back();
    int g;
    logic [47:0] v;
    logic [31:0] exp_v;
    g = 3;
    ready_in[g] = 1'b1; valid_in[g] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      v = rand48(); vec_in[g] = v; exp_v = ref_layer(v);
      tick();
      total++; if (valid_out[g] !== 1'b1) begin bad++; $display("FAIL b2b_valid #%0d: got %b want 1", k, valid_out[g]); end
      total++; if (vec_out[g] !== exp_v) begin bad++; $display("FAIL b2b_vector #%0d: got %h want %h", k, vec_out[g], exp_v); end
      total++; if (ready_out[g] !== 1'b1) begin bad++; $display("FAIL b2b_ready #%0d: got %b want 1", k, ready_out[g]); end
    end
    valid_in[g] = 1'b0;
    tick();
    total++; if (valid_out[g] !== 1'b0) begin bad++; $display("FAIL b2b_drain_valid: got %b want 0", valid_out[g]); end
    ready_in[g] = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int g;
    logic [47:0] v, f;
    g = 0;
    v = 48'hFFFF_FFFF_FFFF ^ rand48(); f = rand48();
    ready_in[g] = 1'b0; valid_in[g] = 1'b1; vec_in[g] = v;
    tick();
    valid_in[g] = 1'b0;
    tick(); tick(); tick();
    rst_n[g] = 1'b0;
    #1;
    total++; if (valid_out[g] !== 1'b0) begin bad++; $display("FAIL rst_busy_valid: got %b want 0", valid_out[g]); end
    total++; if (vec_out[g] !== 32'h0) begin bad++; $display("FAIL rst_busy_vector: got %h want 0", vec_out[g]); end
    total++; if (ready_out[g] !== 1'b1) begin bad++; $display("FAIL rst_busy_ready: got %b want 1", ready_out[g]); end
    #2;
    rst_n[g] = 1'b1;
    tick();
    test_latency(g, f, ref_layer(f), 8, "rst_fresh");
  endtask

  task automatic test_random_sweep();
    localparam int N = 250;
    int sent, got, cyc;
    logic acc, con;
    logic [31:0] exp_v;
    logic [31:0] q[$];
    for (int g = 0; g < 4; g++) begin
      sent = 0; got = 0; cyc = 0; q.delete();
      valid_in[g] = 1'b0; ready_in[g] = 1'b0;
      while ((sent < N || got < N) && cyc < 20000) begin
        if (sent < N && !valid_in[g] && $urandom_range(0, 3) != 0) begin
          vec_in[g] = rand48(); valid_in[g] = 1'b1;
        end
        ready_in[g] = (sent >= N) ? 1'b1 : ($urandom_range(0, 3) != 0);
        #1;
        acc = valid_in[g] && ready_out[g];
        con = valid_out[g] && ready_in[g];
        if (con) begin
          total++;
          if (q.size() == 0) begin
            bad++; $display("FAIL sweep_extra L%0d: got %h with nothing outstanding", 1 << g, vec_out[g]);
          end else begin
            exp_v = q.pop_front();
            if (vec_out[g] !== exp_v) begin
              bad++; $display("FAIL sweep_vector L%0d #%0d: got %h want %h", 1 << g, got, vec_out[g], exp_v);
            end
          end
          got++;
        end
        if (acc) begin q.push_back(ref_layer(vec_in[g])); sent++; end
        @(posedge clk);
        #1;
        if (acc) valid_in[g] = 1'b0;
        cyc++;
      end
      total++;
      if (got != N || q.size() != 0) begin
        bad++; $display("FAIL sweep_count L%0d: got %0d results want %0d (outstanding %0d)", 1 << g, got, N, q.size());
      end
      valid_in[g] = 1'b0; ready_in[g] = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_latency(1, 48'h0, 32'hD4C27AFE, 4, "all_zero");
    test_latency(0, 48'h00000000001B, 32'hD4C27AF5, 8, "s1_row_col");
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    test_random_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
